fp_div_postnorm: RTL and testbench

Normalise/round stage for the floating-point divider. Accepts the raw quotient of the two 24-bit significands, the pre-biased exponent and the result sign from the divide core, and emits a packed IEEE-754 single-precision result with exception flags. Two-stage valid/ready pipeline between the significand divider and the ALU result mux. No subnormal support: underflow flushes to signed zero.

---
 rtl/fp_div_pkg.sv | 21 ++
 rtl/fp_div_postnorm_round.sv | 30 +++
 rtl/fp_div_postnorm.sv | 148 ++++++++++++++
 tb/tb_fp_div_postnorm.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the floating-point divider datapath.
package fp_div_pkg;

  localparam int          FP_EXP_BIAS = 127;
  localparam int          FP_EXP_MAX  = 255;
  localparam logic [31:0] FP_QNAN     = 32'h7FC00000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    ZERO   = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } fp_class_e;

endpackage

// File: rtl/fp_div_postnorm_round.sv
// Combinational rounding of a normalised significand.
// FP_DIV_RNE_EN selects round-to-nearest-even; otherwise truncation.
module fp_round_rne #(
  parameter int EXP_W = 10
) (
  input  logic [22:0]        frac,
  input  logic               guard,
  input  logic               sticky,
  input  logic signed [EXP_W:0] exp,
  output logic [22:0]        frac_r,
  output logic signed [EXP_W:0] exp_r,
  output logic               carry,
  output logic               inexact
);

  logic round_up;

  always_comb begin
`ifdef FP_DIV_RNE_EN
    round_up = guard & (sticky | frac[0]);
`else
    round_up = 1'b0;
`endif
    // A carry out of the fraction leaves frac at zero and bumps the exponent.
    {carry, frac_r} = {1'b0, frac} + {23'd0, round_up};
    exp_r   = exp + $signed({{EXP_W{1'b0}}, carry});
    inexact = guard | sticky;
  end

endmodule

// File: rtl/fp_div_postnorm.sv
// Normalise/round stage of the FP divider: two-stage valid/ready pipeline.
// Rounding mode chosen by FP_DIV_RNE_EN (defined: RNE, undefined: truncate).
module fp_div_postnorm
  import fp_div_pkg::*;
#(
  parameter int EXP_W  = 10,
  parameter int QUOT_W = 26
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [QUOT_W-1:0]       in_quot,
  input  logic                    in_rem_nz,
  input  logic                    in_nan,
  input  logic                    in_inf,
  input  logic                    in_zero,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_result,
  output logic                    out_ovf,
  output logic                    out_unf,
  output logic                    out_inexact
);

  localparam logic signed [EXP_W:0] EXP_MAX_S = (EXP_W+1)'(FP_EXP_MAX);
  localparam logic signed [EXP_W:0] EXP_ZERO  = '0;
  localparam logic signed [EXP_W:0] EXP_ONE   = (EXP_W+1)'(1);

  // Handshake: a beat moves on a rising edge when valid & ready are both high;
  // ready never depends on valid of the same side, only on downstream state.
  logic s1_valid, s2_valid, s1_adv, s2_adv;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = s2_adv || !s1_valid;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  logic signed [EXP_W:0] exp_ext, exp_n, exp_r;
  logic [22:0]           frac_n, frac_r;
  logic                  guard_n, sticky_n, carry_r, inexact_r;
  fp_class_e             class_n;

  always_comb begin
    exp_ext = {in_exp[EXP_W-1], in_exp};
    if (in_quot[25]) begin
      frac_n   = in_quot[24:2];
      guard_n  = in_quot[1];
      sticky_n = in_quot[0] | in_rem_nz;
      exp_n    = exp_ext;
    end else begin
      frac_n   = in_quot[23:1];
      guard_n  = in_quot[0];
      sticky_n = in_rem_nz;
      exp_n    = exp_ext - EXP_ONE;
    end
    if (in_nan)       class_n = NAN;
    else if (in_inf)  class_n = INF;
    else if (in_zero) class_n = ZERO;
    else              class_n = NORMAL;
  end

  fp_round_rne #(.EXP_W(EXP_W)) u_round (
    .frac    (frac_n),
    .guard   (guard_n),
    .sticky  (sticky_n),
    .exp     (exp_n),
    .frac_r  (frac_r),
    .exp_r   (exp_r),
    .carry   (carry_r),
    .inexact (inexact_r)
  );

  logic                  s1_sign, s1_inexact;
  logic [22:0]           s1_frac;
  logic signed [EXP_W:0] s1_exp;
  fp_class_e             s1_class;

  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_sign    <= in_sign;
      s1_frac    <= frac_r;
      s1_exp     <= exp_r;
      s1_inexact <= inexact_r;
      s1_class   <= class_n;
    end
  end

  fp32_t res;
  logic  ovf, unf, inx;

  always_comb begin
    res      = '0;
    res.sign = s1_sign;
    ovf      = 1'b0;
    unf      = 1'b0;
    inx      = 1'b0;
    case (s1_class)
      NAN:  res = FP_QNAN;
      INF:  res.exp = 8'hFF;
      ZERO: ;
      default: begin
        if (s1_exp >= EXP_MAX_S) begin
          ovf = 1'b1;
          inx = 1'b1;
`ifdef FP_DIV_RNE_EN
          res.exp = 8'hFF;
`else
          res.exp  = 8'hFE;
          res.frac = 23'h7FFFFF;
`endif
        end else if (s1_exp <= EXP_ZERO) begin
          unf = 1'b1;
          inx = 1'b1;
        end else begin
          res.exp  = s1_exp[7:0];
          res.frac = s1_frac;
          inx      = s1_inexact;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      out_result  <= '0;
      out_ovf     <= 1'b0;
      out_unf     <= 1'b0;
      out_inexact <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_result  <= res;
          out_ovf     <= ovf;
          out_unf     <= unf;
          out_inexact <= inx;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_div_postnorm.sv
// Directed bench for fp_div_postnorm: vector table, latency, back-pressure, mid-flight reset.
module tb_fp_div_postnorm;

`ifdef FP_DIV_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  logic              clk, rst;
  logic              in_valid, in_ready, in_sign, in_rem_nz, in_nan, in_inf, in_zero;
  logic signed [9:0] in_exp;
  logic [25:0]       in_quot;
  logic              out_valid, out_ready, out_ovf, out_unf, out_inexact;
  logic [31:0]       out_result;

  fp_div_postnorm #(.EXP_W(10), .QUOT_W(26)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_quot(in_quot), .in_rem_nz(in_rem_nz),
    .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_ovf(out_ovf), .out_unf(out_unf), .out_inexact(out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              sign;
    logic signed [9:0] exp;
    logic [25:0]       quot;
    logic              rem;
    logic [2:0]        cls;  // {nan, inf, zero}
    logic [31:0]       res;
    logic [2:0]        fl;   // {ovf, unf, inexact}
  } vec_t;

  vec_t        tbl[$];
  logic [34:0] exp_q[$];
  int          total, bad, popped;
  bit          saw_block;

  function automatic vec_t mk(logic s, int e, logic [25:0] q, logic r, logic [2:0] c,
                              logic [31:0] res, logic [2:0] fl);
    vec_t v;
    v.sign = s; v.exp = 10'(e); v.quot = q; v.rem = r; v.cls = c; v.res = res; v.fl = fl;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic drive(input vec_t v);
    in_sign   = v.sign;
    in_exp    = v.exp;
    in_quot   = v.quot;
    in_rem_nz = v.rem;
    {in_nan, in_inf, in_zero} = v.cls;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input vec_t v);
    int waited;
    drive(v);
    in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout in_ready=%b want=1", in_ready);
    end else begin
      exp_q.push_back({v.res, v.fl});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic latency_check(input vec_t v, input string name);
    drive(v);
    in_valid = 1'b1;
    @(negedge clk);
    check({name, "_acc"}, 64'(in_ready), 64'd1);
    exp_q.push_back({v.res, v.fl});
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check({name, "_c1"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check({name, "_c2"}, 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic monitor_loop();
    logic [34:0] hold, got;
    bit          stalled;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      got = {out_result, out_ovf, out_unf, out_inexact};
      if (rst) begin
        stalled = 1'b0;
      end else if (out_valid && !out_ready) begin
        if (stalled) check("stall_hold", 64'(got), 64'(hold));
        hold    = got;
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
        if (out_valid && out_ready) begin
          popped++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_beat got=%h want=none", got);
          end else begin
            check("result", 64'(got), 64'(exp_q.pop_front()));
          end
        end
      end
    end
  endtask

  initial begin
    total = 0; bad = 0; popped = 0; saw_block = 1'b0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(mk(0, 0, 26'd0, 0, 3'b000, 32'd0, 3'b000));

    // name         sign exp  quot         rem cls     result                                   {ovf,unf,inx}
    tbl.push_back(mk(0, 128, 26'h3000000, 0, 3'b000, 32'h40400000,                          3'b000));
    tbl.push_back(mk(0, 127, 26'h1555555, 1, 3'b000, RNE ? 32'h3F2AAAAB : 32'h3F2AAAAA,      3'b001));
    tbl.push_back(mk(0, 130, 26'h1FFFFFF, 1, 3'b000, RNE ? 32'h41000000 : 32'h40FFFFFF,      3'b001));
    tbl.push_back(mk(0, 256, 26'h2000000, 0, 3'b000, RNE ? 32'h7F800000 : 32'h7F7FFFFF,      3'b101));
    tbl.push_back(mk(0, 1,   26'h1800000, 0, 3'b000, 32'h00000000,                          3'b011));
    tbl.push_back(mk(1, 300, 26'h2000000, 1, 3'b100, 32'h7FC00000,                          3'b000));
    tbl.push_back(mk(1, 127, 26'h2000000, 0, 3'b010, 32'hFF800000,                          3'b000));
    tbl.push_back(mk(1, 127, 26'h2000000, 0, 3'b001, 32'h80000000,                          3'b000));
    tbl.push_back(mk(0, 254, 26'h2000000, 0, 3'b000, 32'h7F000000,                          3'b000));
    tbl.push_back(mk(1, 255, 26'h2000000, 0, 3'b000, RNE ? 32'hFF800000 : 32'hFF7FFFFF,      3'b101));
    tbl.push_back(mk(0, 255, 26'h1FFFFFF, 0, 3'b000, RNE ? 32'h7F800000 : 32'h7F7FFFFF,
                     RNE ? 3'b101 : 3'b001));
    tbl.push_back(mk(0, 127, 26'h2000002, 0, 3'b000, 32'h3F800000,                          3'b001));
    tbl.push_back(mk(0, 127, 26'h2000006, 0, 3'b000, RNE ? 32'h3F800002 : 32'h3F800001,      3'b001));
    tbl.push_back(mk(1, -126, 26'h2000000, 0, 3'b000, 32'h80000000,                         3'b011));
    tbl.push_back(mk(0, 380, 26'h2000000, 0, 3'b000, RNE ? 32'h7F800000 : 32'h7F7FFFFF,      3'b101));
    tbl.push_back(mk(0, 1,   26'h2000000, 0, 3'b000, 32'h00800000,                          3'b000));
    tbl.push_back(mk(1, 127, 26'h2000000, 0, 3'b000, 32'hBF800000,                          3'b000));
    tbl.push_back(mk(0, 127, 26'h2000001, 0, 3'b000, 32'h3F800000,                          3'b001));

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {out_valid, in_ready, out_result, out_ovf, out_unf, out_inexact},
          {1'b0, 1'b1, 32'd0, 3'b000});
    @(negedge clk) rst = 1'b0;

    fork
      monitor_loop();
      begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
      end
    join_none

    @(posedge clk);
    #1;
    latency_check(tbl[0], "latency");

    foreach (tbl[i]) send(tbl[i]);
    drain("table_drain");

    // Eight distinct beats, downstream stalled for three cycles mid-stream.
    popped = 0;
    fork
      for (int i = 0; i < 8; i++)
        send(mk(0, 120 + i, 26'h2000000, 0, 3'b000, 32'((120 + i) << 23), 3'b000));
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (!in_ready) saw_block = 1'b1;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    check("bp_count", 64'(popped), 64'd8);
    check("bp_in_ready_low", 64'(saw_block), 64'd1);

    // Fill both stages, then reset asynchronously mid-cycle.
    out_ready = 1'b0;
    send(tbl[1]);
    send(tbl[2]);
    check("full_before_rst", {62'd0, out_valid, in_ready}, {62'd0, 1'b1, 1'b0});
    #2 rst = 1'b1;
    #1;
    check("midflight_rst", {out_valid, in_ready, out_result, out_ovf, out_unf, out_inexact},
          {1'b0, 1'b1, 32'd0, 3'b000});
    exp_q.delete();
    out_ready = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    latency_check(tbl[2], "post_rst");
    drain("final_drain");
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
